// File: rtl/video_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_chk_pkg
// Description : Shared types and constants for the AXI-stream video checker.
// Revision    : 1.0 - initial release
// ============================================================================
package video_chk_pkg;

    typedef enum logic [0:0] {
        SEEK_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int ERR_SOF  = 0;
    localparam int ERR_EOL  = 1;
    localparam int ERR_DATA = 2;
    localparam int ERR_W    = 3;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_ready_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_ready_gen
// Description : Registered stream-ready with optional LFSR throttling.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_ready_gen
    import video_chk_pkg::*;
#(
    parameter int          BP_EN = 0,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic clock,
    input  logic rst,
    input  logic enable,
    output logic ready
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        ready_q;
    logic        ready_d;

    // LFSR free-runs every cycle; it only gates ready when throttling is on
    always_comb begin
        lfsr_d  = lfsr_next(lfsr_q);
        ready_d = enable & ((BP_EN == 0) | lfsr_q[1] | lfsr_q[0]);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            lfsr_q  <= SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

endmodule
`default_nettype wire

// File: rtl/axis_video_checker.sv
`default_nettype none
// ============================================================================
// Module      : axis_video_checker
// Description : AXI-stream video sink checking frame geometry and pixel ramp.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_video_checker
    import video_chk_pkg::*;
#(
    parameter int          DSIZE     = 24,
    parameter int          H_ACTIVE  = 1920,
    parameter int          V_ACTIVE  = 1080,
    parameter int          BP_EN     = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [DSIZE-1:0] axi_tdata,
    input  logic             axi_tvalid,
    output logic             axi_tready,
    input  logic             axi_tuser,
    input  logic             axi_tlast,
    output logic             locked,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             err_sof,
    output logic             err_eol,
    output logic             err_data,
    output logic [15:0]      err_cnt
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d, x_eff;
    logic [YW-1:0]       y_q, y_d, y_eff;
    logic                locked_q, locked_d;
    logic                done_q, done_d;
    logic [15:0]         fcnt_q, fcnt_d;
    logic [ERR_W-1:0]    err_q, err_d, err_ev;
    logic [15:0]         ecnt_q, ecnt_d;
    logic                beat;
    logic                take;
    logic                sof_ev;
    logic                last_x;
    logic                line_end;
    logic [DSIZE-1:0]    exp_data;

    lfsr_ready_gen #(
        .BP_EN (BP_EN),
        .SEED  (LFSR_SEED)
    ) u_ready (
        .clock  (clock),
        .rst    (rst),
        .enable (enable),
        .ready  (axi_tready)
    );

    assign beat = axi_tvalid & axi_tready;

    generate
        if (DSIZE > XW) begin : g_exp_wide
            assign exp_data = {{(DSIZE - XW){1'b0}}, x_eff};
        end else begin : g_exp_narrow
            assign exp_data = x_eff[DSIZE-1:0];
        end
    endgenerate

    // Decide whether the beat belongs to a frame and where it sits in it;
    // a misplaced tuser realigns the beat to the origin of a new frame.
    always_comb begin
        take     = 1'b0;
        sof_ev   = 1'b0;
        x_eff    = x_q;
        y_eff    = y_q;
        locked_d = locked_q;
        if (beat) begin
            case (state_q)
                SEEK_SOF: begin
                    if (axi_tuser) begin
                        take     = 1'b1;
                        x_eff    = '0;
                        y_eff    = '0;
                        locked_d = 1'b1;
                    end else if (locked_q) begin
                        sof_ev = 1'b1;
                    end
                end
                IN_FRAME: begin
                    take = 1'b1;
                    if (axi_tuser && ((x_q != '0) || (y_q != '0))) begin
                        sof_ev = 1'b1;
                        x_eff  = '0;
                        y_eff  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        done_d   = 1'b0;
        fcnt_d   = fcnt_q;
        last_x   = (x_eff == XW'(H_ACTIVE - 1));
        line_end = axi_tlast | last_x;
        err_ev   = '0;
        err_ev[ERR_SOF] = sof_ev;
        if (take) begin
            err_ev[ERR_DATA] = (axi_tdata != exp_data);
            err_ev[ERR_EOL]  = (axi_tlast != last_x);
            state_d          = IN_FRAME;
            if (line_end) begin
                x_d = '0;
                if (y_eff == YW'(V_ACTIVE - 1)) begin
                    y_d     = '0;
                    state_d = SEEK_SOF;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                end else begin
                    y_d = y_eff + YW'(1);
                end
            end else begin
                x_d = x_eff + XW'(1);
                y_d = y_eff;
            end
        end
        err_d  = err_q | err_ev;
        ecnt_d = ((|err_ev) && (ecnt_q != 16'hFFFF)) ? ecnt_q + 16'd1 : ecnt_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= SEEK_SOF;
            x_q      <= '0;
            y_q      <= '0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            fcnt_q   <= '0;
            err_q    <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            fcnt_q   <= fcnt_d;
            err_q    <= err_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign locked     = locked_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;
    assign err_sof    = err_q[ERR_SOF];
    assign err_eol    = err_q[ERR_EOL];
    assign err_data   = err_q[ERR_DATA];
    assign err_cnt    = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_video_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_video_checker
// Description : Directed self-checking bench for axis_video_checker (8x4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_video_checker;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int DW = 24;

    logic          clock  = 1'b0;
    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic          tvalid = 1'b0;
    logic          tuser  = 1'b0;
    logic          tlast  = 1'b0;
    logic [DW-1:0] tdata  = '0;

    logic        rdy0, lk0, fd0, es0, ee0, ed0;
    logic [15:0] fc0, ec0;
    logic        rdy1, lk1, fd1, es1, ee1, ed1;
    logic [15:0] fc1, ec1;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int fd0n  = 0;
    int fd1n  = 0;
    int stall1 = 0;
    int f;

    axis_video_checker #(.DSIZE(DW), .H_ACTIVE(H), .V_ACTIVE(V), .BP_EN(0)) dut0 (
        .clock(clock), .rst(rst), .enable(enable), .axi_tdata(tdata),
        .axi_tvalid(tvalid), .axi_tready(rdy0), .axi_tuser(tuser), .axi_tlast(tlast),
        .locked(lk0), .frame_done(fd0), .frame_cnt(fc0), .err_sof(es0),
        .err_eol(ee0), .err_data(ed0), .err_cnt(ec0)
    );

    axis_video_checker #(.DSIZE(DW), .H_ACTIVE(H), .V_ACTIVE(V), .BP_EN(1)) dut1 (
        .clock(clock), .rst(rst), .enable(enable), .axi_tdata(tdata),
        .axi_tvalid(tvalid), .axi_tready(rdy1), .axi_tuser(tuser), .axi_tlast(tlast),
        .locked(lk1), .frame_done(fd1), .frame_cnt(fc1), .err_sof(es1),
        .err_eol(ee1), .err_data(ed1), .err_cnt(ec1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (fd0) fd0n <= fd0n + 1;
        if (fd1) fd1n <= fd1n + 1;
        if (sel == 1 && !rst && enable && !rdy1) stall1 <= stall1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until the selected sink accepts it
    task automatic beat(input logic [DW-1:0] d, input logic u, input logic l);
        int   n;
        logic r;
        tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
        n = 0;
        forever begin
            @(negedge clock);
            r = (sel == 0) ? rdy0 : rdy1;
            if (r) begin
                @(posedge clock); #1;
                break;
            end
            n++;
            if (n > 200) begin
                check("beat_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    // kind: 0 clean, 1 bad pixel at (3,1), 2 early tlast at (5,2), 4 enable pause at (4,1)
    task automatic frame(input int kind);
        int            xend;
        logic [DW-1:0] d;
        for (int y = 0; y < V; y++) begin
            xend = (kind == 2 && y == 2) ? 5 : H - 1;
            for (int x = 0; x <= xend; x++) begin
                d = DW'(x);
                if (kind == 1 && y == 1 && x == 3) d = 24'd5;
                if (kind == 4 && y == 1 && x == 4) begin
                    tvalid = 1'b0;
                    enable = 1'b0;
                    repeat (4) @(posedge clock);
                    #1;
                    check("tready_low_disabled", {31'd0, rdy0}, 32'd0);
                    enable = 1'b1;
                end
                beat(d, (x == 0 && y == 0), (x == xend));
            end
        end
        idle(3);
    endtask

    initial begin
        enable = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_tready", {31'd0, rdy0}, 32'd0);
        check("rst_flags", {27'd0, lk0, fd0, es0, ee0, ed0}, 32'd0);
        check("rst_counts", {fc0, ec0}, 32'd0);
        rst = 1'b0;

        f = fd0n;
        repeat (3) frame(0);
        check("clean_frame_cnt", {16'd0, fc0}, 32'd3);
        check("clean_done_pulses", fd0n - f, 32'd3);
        check("clean_errs", {29'd0, es0, ee0, ed0}, 32'd0);
        check("clean_err_cnt", {16'd0, ec0}, 32'd0);
        check("clean_locked", {31'd0, lk0}, 32'd1);

        frame(1);
        check("data_err_flags", {29'd0, es0, ee0, ed0}, 32'd1);
        check("data_err_cnt", {16'd0, ec0}, 32'd1);
        check("data_frame_cnt", {16'd0, fc0}, 32'd4);

        f = fd0n;
        frame(2);
        check("eol_err_flag", {31'd0, ee0}, 32'd1);
        check("eol_err_cnt", {16'd0, ec0}, 32'd2);
        check("eol_frame_cnt", {16'd0, fc0}, 32'd5);
        check("eol_done_pulse", fd0n - f, 32'd1);

        // tuser at (2,1): the aborted frame gives no pulse, the new one completes
        f = fd0n;
        for (int x = 0; x < H; x++) beat(DW'(x), (x == 0), (x == H - 1));
        beat(24'd0, 1'b0, 1'b0);
        beat(24'd1, 1'b0, 1'b0);
        frame(0);
        check("sof_err_flag", {31'd0, es0}, 32'd1);
        check("sof_err_cnt", {16'd0, ec0}, 32'd3);
        check("sof_frame_cnt", {16'd0, fc0}, 32'd6);
        check("sof_done_pulse", fd0n - f, 32'd1);

        beat(24'd7, 1'b0, 1'b0);
        idle(2);
        check("stray_after_lock", {16'd0, ec0}, 32'd4);

        frame(4);
        check("pause_err_cnt", {16'd0, ec0}, 32'd4);
        check("pause_frame_cnt", {16'd0, fc0}, 32'd7);

        // reset in the middle of a frame
        for (int x = 0; x < H; x++) beat(DW'(x), (x == 0), (x == H - 1));
        for (int x = 0; x < 4; x++) beat(DW'(x), 1'b0, 1'b0);
        do_reset();
        check("midrst_flags", {27'd0, lk0, fd0, es0, ee0, ed0}, 32'd0);
        check("midrst_counts", {fc0, ec0}, 32'd0);
        beat(24'd3, 1'b0, 1'b0);
        beat(24'd4, 1'b0, 1'b1);
        idle(2);
        check("prelock_no_err", {13'd0, es0, ee0, ed0, ec0}, 32'd0);
        frame(0);
        check("postrst_frame_cnt", {16'd0, fc0}, 32'd1);
        check("postrst_errs", {13'd0, es0, ee0, ed0, ec0}, 32'd0);
        check("postrst_locked", {31'd0, lk0}, 32'd1);

        // throttled sink
        sel = 1;
        do_reset();
        f = fd1n;
        repeat (3) frame(0);
        check("bp_frame_cnt", {16'd0, fc1}, 32'd3);
        check("bp_done_pulses", fd1n - f, 32'd3);
        check("bp_errs", {13'd0, es1, ee1, ed1, ec1}, 32'd0);
        check("bp_locked", {31'd0, lk1}, 32'd1);
        check("bp_stalled", {31'd0, (stall1 != 0)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
